// File: rtl/pic_inta_sequencer.sv
// pic_inta_sequencer: CPU-side interrupt-acknowledge sequencer for an 8259A PIC.
// Synchronizes INT and, when ACK_EN allows, drives a train of INTA low pulses.
// It captures the byte on DATA_IN at the last low cycle of each pulse, then
// presents the completed vector with a one-cycle VECTOR_VALID strobe.
// Optional feature macro: PIC_8085_MODE_EN. When defined, the sequencer uses the
// 3-pulse 8085 CALL sequence and checks the opcode. When undefined, it uses the
// 2-pulse 8086 sequence and OPCODE_ERR stays 0.
module pic_inta_sequencer #(
    parameter int PULSE_LOW   = 2,
    parameter int PULSE_GAP   = 2,
    parameter int HOLD_CYCLES = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        INT,
    input  logic        ACK_EN,
    input  logic [7:0]  DATA_IN,
    output logic        INTA,
    output logic [7:0]  VECTOR,
    output logic [15:0] VECTOR_ADDR,
    output logic        VECTOR_VALID,
    output logic        BUSY,
    output logic        OPCODE_ERR
);

    localparam int MAX_LG  = (PULSE_LOW > PULSE_GAP) ? PULSE_LOW : PULSE_GAP;
    localparam int MAX_CNT = (MAX_LG > HOLD_CYCLES) ? MAX_LG : HOLD_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

`ifdef PIC_8085_MODE_EN
    localparam int NP = 3;
`else
    localparam int NP = 2;
`endif

    localparam logic [1:0]       LAST_PIDX = 2'(NP - 1);
    localparam logic [CNT_W-1:0] LOAD_LOW  = CNT_W'(PULSE_LOW - 1);
    localparam logic [CNT_W-1:0] LOAD_GAP  = CNT_W'(PULSE_GAP - 1);
    localparam logic [CNT_W-1:0] LOAD_HOLD = CNT_W'(HOLD_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOW,
        ST_GAP,
        ST_DONE,
        ST_HOLD
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic [1:0]       r_pidx;
    logic [1:0]       w_pidx_next;
    logic             w_capture;
    logic             w_last_capture;
    logic             w_flush;

    logic             r_sync_meta;
    logic             r_sync_ff;
    logic             r_int_s;

    logic             r_inta;
    logic [7:0]       r_vector;
    logic [15:0]      r_vector_addr;
    logic             r_vector_valid;

    // INT synchronizer chain plus a registered int_s.
    // HOLD clears the chain so a stale request cannot restart the sequencer.
    always_ff @(posedge CLK) begin
        // NOTE: state elements use non-blocking assignments so every flop
        // samples the pre-edge values and the chain shifts by exactly one stage.
        if (RST || w_flush) begin
            r_sync_meta <= 1'b0;
            r_sync_ff   <= 1'b0;
            r_int_s     <= 1'b0;
        end else begin
            r_sync_meta <= INT;
            r_sync_ff   <= r_sync_meta;
            r_int_s     <= r_sync_ff;
        end
    end

    // FSM state register with its pulse counter and pulse index.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_pidx  <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_pidx  <= w_pidx_next;
        end
    end

    // Next-state, counter reload/decrement and capture strobes.
    always_comb begin
        // NOTE: every output of this block gets a default first; a path that
        // leaves one unassigned would infer a latch.
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_pidx_next  = r_pidx;
        w_capture    = 1'b0;
        w_flush      = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (r_int_s && ACK_EN) begin
                    w_state_next = ST_LOW;
                    w_cnt_next   = LOAD_LOW;
                    w_pidx_next  = 2'd0;
                end
            end
            ST_LOW: begin
                if (r_cnt == '0) begin
                    w_capture = 1'b1;
                    if (r_pidx == LAST_PIDX) begin
                        w_state_next = ST_DONE;
                    end else begin
                        w_state_next = ST_GAP;
                        w_cnt_next   = LOAD_GAP;
                    end
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            ST_GAP: begin
                if (r_cnt == '0) begin
                    w_state_next = ST_LOW;
                    w_cnt_next   = LOAD_LOW;
                    w_pidx_next  = r_pidx + 2'd1;
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            ST_DONE: begin
                w_state_next = ST_HOLD;
                w_cnt_next   = LOAD_HOLD;
            end
            ST_HOLD: begin
                // The final HOLD cycle lets the synchronizer resample INT, so a
                // request that is still pending restarts after the normal
                // three-edge latency.
                if (r_cnt == '0) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                    w_flush    = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign w_last_capture = w_capture && (r_pidx == LAST_PIDX);

`ifdef PIC_8085_MODE_EN
    logic [7:0] r_lo_byte;
    logic       r_opcode_err;

    // Keep the low address byte, and flag a first byte that is not CALL (0xCD).
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_lo_byte    <= 8'h00;
            r_opcode_err <= 1'b0;
        end else if (w_capture) begin
            if (r_pidx == 2'd0 && DATA_IN != 8'hCD) begin
                r_opcode_err <= 1'b1;
            end
            if (r_pidx == 2'd1) begin
                r_lo_byte <= DATA_IN;
            end
        end
    end

    assign OPCODE_ERR = r_opcode_err;
`else
    assign OPCODE_ERR = 1'b0;
`endif

    // Registered outputs: INTA follows the next state, and the vector loads on DONE entry.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_inta         <= 1'b1;
            r_vector       <= 8'h00;
            r_vector_addr  <= 16'h0000;
            r_vector_valid <= 1'b0;
        end else begin
            r_inta         <= (w_state_next != ST_LOW);
            r_vector_valid <= w_last_capture;
            if (w_last_capture) begin
`ifdef PIC_8085_MODE_EN
                r_vector      <= r_lo_byte;
                r_vector_addr <= {DATA_IN, r_lo_byte};
`else
                r_vector      <= DATA_IN;
                r_vector_addr <= {6'b0, DATA_IN, 2'b00};
`endif
            end
        end
    end

    assign INTA         = r_inta;
    assign VECTOR       = r_vector;
    assign VECTOR_ADDR  = r_vector_addr;
    assign VECTOR_VALID = r_vector_valid;
    assign BUSY         = (r_state != ST_IDLE);

endmodule

// File: tb/tb_pic_inta_sequencer.sv
// tb_pic_inta_sequencer: directed testbench for pic_inta_sequencer with default parameters.
// Inputs change and outputs are sampled 1 ns after each rising edge. Edge numbering
// follows the INT-to-INTA timeline, with edge 3 being the IDLE->LOW edge.
module tb_pic_inta_sequencer;

`ifdef PIC_8085_MODE_EN
    localparam int NP = 3;
`else
    localparam int NP = 2;
`endif

    logic        CLK;
    logic        RST;
    logic        INT;
    logic        ACK_EN;
    logic [7:0]  DATA_IN;
    logic        INTA;
    logic [7:0]  VECTOR;
    logic [15:0] VECTOR_ADDR;
    logic        VECTOR_VALID;
    logic        BUSY;
    logic        OPCODE_ERR;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [7:0]  prev_vec = 8'h00;
    logic        exp_err = 1'b0;

    pic_inta_sequencer dut (
        .CLK          (CLK),
        .RST          (RST),
        .INT          (INT),
        .ACK_EN       (ACK_EN),
        .DATA_IN      (DATA_IN),
        .INTA         (INTA),
        .VECTOR       (VECTOR),
        .VECTOR_ADDR  (VECTOR_ADDR),
        .VECTOR_VALID (VECTOR_VALID),
        .BUSY         (BUSY),
        .OPCODE_ERR   (OPCODE_ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Call this task when the next edge is the IDLE->LOW edge (edge 3).
    // It runs through the end of HOLD (edge v+3) and checks the INTA/BUSY/VALID
    // waveform on every edge.
    task automatic run_seq(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                           input logic [7:0] exp_vec, input logic [15:0] exp_addr,
                           input bit drop);
        int         v;
        logic       exp_low;
        logic [7:0] bytes [3];
        v     = 1 + 4 * NP;
        bytes = '{b0, b1, b2};
        for (int e = 3; e <= v + 3; e++) begin
            if (e <= v) DATA_IN = bytes[(e - 3) / 4];
            tick();
            exp_low = (e < v) && (((e - 3) % 4) < 2);
            check("inta", 32'(INTA), 32'(!exp_low));
            check("busy", 32'(BUSY), 32'(e < v + 3));
            check("valid", 32'(VECTOR_VALID), 32'(e == v));
            if (e == v - 1) check("vec_hold", 32'(VECTOR), 32'(prev_vec));
            if (e == v) begin
                check("vector", 32'(VECTOR), 32'(exp_vec));
                check("vector_addr", 32'(VECTOR_ADDR), 32'(exp_addr));
                prev_vec = exp_vec;
            end
            if (drop && e == 5) begin
                INT    = 1'b0;
                ACK_EN = 1'b0;
            end
        end
        check("opcode_err", 32'(OPCODE_ERR), 32'(exp_err));
    endtask

    // Checks for the quiet window between back-to-back sequences.
    task automatic idle_ticks(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            tick();
            check({tag, "_inta"}, 32'(INTA), 32'd1);
            check({tag, "_busy"}, 32'(BUSY), 32'd0);
            check({tag, "_valid"}, 32'(VECTOR_VALID), 32'd0);
        end
    endtask

    initial begin
        RST     = 1'b1;
        INT     = 1'b1;
        ACK_EN  = 1'b1;
        DATA_IN = 8'h00;

        // Reset holds everything quiet even with INT and ACK_EN asserted.
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rst_inta", 32'(INTA), 32'd1);
            check("rst_busy", 32'(BUSY), 32'd0);
            check("rst_vector", 32'(VECTOR), 32'd0);
            check("rst_addr", 32'(VECTOR_ADDR), 32'd0);
            check("rst_valid", 32'(VECTOR_VALID), 32'd0);
            check("rst_err", 32'(OPCODE_ERR), 32'd0);
        end
        RST = 1'b0;

        // Edges 0..2 are synchronizer latency, and no pulse appears yet.
        idle_ticks(3, "sync");

        // Basic acknowledge sequence.
`ifdef PIC_8085_MODE_EN
        run_seq(8'hCD, 8'h34, 8'h12, 8'h34, 16'h1234, 1'b0);
`else
        run_seq(8'hFF, 8'h48, 8'h00, 8'h48, 16'h0120, 1'b0);
`endif

        // Back-to-back: INT is still high, so the next start is 1+HOLD+3 edges after DONE.
        idle_ticks(2, "b2b");
`ifdef PIC_8085_MODE_EN
        exp_err = 1'b1;
        run_seq(8'h00, 8'h78, 8'h56, 8'h78, 16'h5678, 1'b0);
`else
        run_seq(8'hAA, 8'h81, 8'h00, 8'h81, 16'h0204, 1'b0);
`endif

        // Gating: INT stays high with ACK_EN low, and no pulses are produced.
        ACK_EN = 1'b0;
        idle_ticks(10, "gate");
        check("gate_err", 32'(OPCODE_ERR), 32'(exp_err));

        // Persistence: INT and ACK_EN drop after pulse 0, and the sequence still finishes.
        ACK_EN = 1'b1;
`ifdef PIC_8085_MODE_EN
        run_seq(8'hCD, 8'h9A, 8'hBC, 8'h9A, 16'hBC9A, 1'b1);
`else
        run_seq(8'h00, 8'h3F, 8'h00, 8'h3F, 16'h00FC, 1'b1);
`endif

        // Reset asserted during GAP.
        INT    = 1'b1;
        ACK_EN = 1'b1;
        DATA_IN = 8'h5A;
        repeat (6) tick();
        check("gap_inta", 32'(INTA), 32'd1);
        check("gap_busy", 32'(BUSY), 32'd1);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        INT = 1'b0;
        exp_err  = 1'b0;
        prev_vec = 8'h00;
        check("midrst_inta", 32'(INTA), 32'd1);
        check("midrst_busy", 32'(BUSY), 32'd0);
        check("midrst_valid", 32'(VECTOR_VALID), 32'd0);
        check("midrst_vector", 32'(VECTOR), 32'd0);
        check("midrst_addr", 32'(VECTOR_ADDR), 32'd0);
        check("midrst_err", 32'(OPCODE_ERR), 32'd0);
        idle_ticks(4, "post_rst");

        // A fresh request after the reset completes normally.
        INT = 1'b1;
        idle_ticks(3, "fresh_sync");
`ifdef PIC_8085_MODE_EN
        run_seq(8'hCD, 8'h22, 8'h33, 8'h22, 16'h3322, 1'b0);
`else
        run_seq(8'h11, 8'h22, 8'h33, 8'h22, 16'h0088, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
